// File: rtl/lifo_stack_param_if.sv
// Bus bundle for lifo_stack_param: control, data and status between producer/consumer and stack.
interface lifo_stack_param_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             clr;
   logic             wn;
   logic             rn;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic             full;
   logic             empty;
   logic             afull;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output clr, wn, rn, in,
      input  out, full, empty, afull, count, overflow, underflow
   );

   modport slave (
      input  clr, wn, rn, in,
      output out, full, empty, afull, count, overflow, underflow
   );
endinterface

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with occupancy count, almost-full flag, synchronous
// flush, replace-top on simultaneous push/pop and one-cycle error pulses.
module lifo_stack_param #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 1
) (
   input logic               clk,
   input logic               rst,
   lifo_stack_param_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_sp;
   logic [WIDTH-1:0] r_out;
   logic             r_ovf;
   logic             r_unf;

   logic             w_full;
   logic             w_empty;
   logic             w_afull;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_wr_idx;
   logic             w_mem_we;

   // Status flags derived directly from the stack pointer.
   always_comb begin
      w_full    = (r_sp == CW'(DEPTH));
      w_empty   = (r_sp == '0);
      w_afull   = (r_sp >= CW'(AF_LEVEL));
      w_top_idx = AW'(r_sp - CW'(1));
   end

   // Memory write decode: a push writes above the top, a replace overwrites the top.
   always_comb begin
      w_mem_we = 1'b0;
      w_wr_idx = AW'(r_sp);
      if (!bus.clr) begin
         if (bus.wn && !bus.rn && !w_full) begin
            w_mem_we = 1'b1;
         end else if (bus.wn && bus.rn && !w_empty) begin
            w_mem_we = 1'b1;
            w_wr_idx = w_top_idx;
         end
      end
   end

   // Storage array; contents are don't-care after reset so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_wr_idx] <= bus.in;
      end
   end

   // Stack pointer, registered read data and error pulses; clr dominates wn/rn.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sp  <= '0;
         r_out <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         if (bus.clr) begin
            r_sp <= '0;
         end else begin
            case ({bus.wn, bus.rn})
               2'b10: begin
                  if (w_full) r_ovf <= 1'b1;
                  else        r_sp  <= r_sp + CW'(1);
               end
               2'b01: begin
                  if (w_empty) begin
                     r_unf <= 1'b1;
                  end else begin
                     r_out <= r_mem[w_top_idx];
                     r_sp  <= r_sp - CW'(1);
                  end
               end
               2'b11: begin
                  // Empty replace bypasses input straight to out without touching sp.
                  if (w_empty) r_out <= bus.in;
                  else         r_out <= r_mem[w_top_idx];
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.count     = r_sp;
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
   assign bus.afull     = w_afull;
   assign bus.overflow  = r_ovf;
   assign bus.underflow = r_unf;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench: two stack configurations checked every cycle against a
// array-based stack model, plus hand-computed literal expectations.
module tb_lifo_stack_param;
   logic clk = 1'b0;
   logic rst;

   lifo_stack_param_if #(.WIDTH(8),  .DEPTH(8)) if0 ();
   lifo_stack_param_if #(.WIDTH(16), .DEPTH(5)) if1 ();

   lifo_stack_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7)) d0 (
      .clk(clk), .rst(rst), .bus(if0.slave)
   );
   lifo_stack_param #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(3)) d1 (
      .clk(clk), .rst(rst), .bus(if1.slave)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          mdep [2] = '{8, 5};
   int          maf  [2] = '{7, 3};
   logic [15:0] mst  [2][8];
   int          msp  [2];
   logic [15:0] mout [2];
   bit          mov  [2];
   bit          mun  [2];

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         msp[k] = 0; mout[k] = '0; mov[k] = 0; mun[k] = 0;
      end
   endtask

   task automatic m_edge(int k, bit c, bit w, bit r, logic [15:0] d);
      mov[k] = 0;
      mun[k] = 0;
      if (c) begin
         msp[k] = 0;
      end else if (w && !r) begin
         if (msp[k] == mdep[k]) mov[k] = 1;
         else begin mst[k][msp[k]] = d; msp[k] = msp[k] + 1; end
      end else if (!w && r) begin
         if (msp[k] == 0) mun[k] = 1;
         else begin msp[k] = msp[k] - 1; mout[k] = mst[k][msp[k]]; end
      end else if (w && r) begin
         if (msp[k] == 0) mout[k] = d;
         else begin mout[k] = mst[k][msp[k]-1]; mst[k][msp[k]-1] = d; end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) m_reset();
      else begin
         m_edge(0, if0.clr, if0.wn, if0.rn, 16'(if0.in));
         m_edge(1, if1.clr, if1.wn, if1.rn, if1.in);
      end
   end

   task automatic cmp_inst(string t, int k, logic [15:0] o, int cnt,
                           bit f, bit e, bit af, bit ov, bit un);
      chk({t, ".out"},       32'(o),   32'(mout[k]));
      chk({t, ".count"},     32'(cnt), 32'(msp[k]));
      chk({t, ".full"},      32'(f),   32'(msp[k] == mdep[k]));
      chk({t, ".empty"},     32'(e),   32'(msp[k] == 0));
      chk({t, ".afull"},     32'(af),  32'(msp[k] >= maf[k]));
      chk({t, ".overflow"},  32'(ov),  32'(mov[k]));
      chk({t, ".underflow"}, 32'(un),  32'(mun[k]));
   endtask

   // Per-cycle comparison away from the active edge.
   always @(negedge clk) begin
      cmp_inst("d0", 0, 16'(if0.out), int'(if0.count), if0.full, if0.empty,
               if0.afull, if0.overflow, if0.underflow);
      cmp_inst("d1", 1, if1.out, int'(if1.count), if1.full, if1.empty,
               if1.afull, if1.overflow, if1.underflow);
   end

   // ---------------- stimulus ----------------
   task automatic idle_all();
      if0.clr = 0; if0.wn = 0; if0.rn = 0; if0.in = '0;
      if1.clr = 0; if1.wn = 0; if1.rn = 0; if1.in = '0;
   endtask

   task automatic step(int k, bit c, bit w, bit r, logic [15:0] d);
      if (k == 0) begin
         if0.clr = c; if0.wn = w; if0.rn = r; if0.in = d[7:0];
      end else begin
         if1.clr = c; if1.wn = w; if1.rn = r; if1.in = d;
      end
      @(posedge clk);
      #2;
      idle_all();
   endtask

   logic [7:0]  fill0 [8] = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15, 8'd9};
   logic [15:0] fill1 [5] = '{16'hBEEF, 16'hCAFE, 16'h1234, 16'h8001, 16'hFFFF};

   initial begin
      idle_all();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("rst.out",   32'(if0.out),   32'd0);
      chk("rst.empty", 32'(if0.empty), 32'd1);
      chk("rst.count", 32'(if0.count), 32'd0);
      chk("rst.full",  32'(if0.full),  32'd0);
      chk("rst.afull", 32'(if0.afull), 32'd0);
      #10 rst = 1'b1;

      // Fill DEPTH=8; afull from count 7.
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 0, 16'(fill0[i]));
         chk("fill.count", 32'(if0.count), 32'(i + 1));
         chk("fill.afull", 32'(if0.afull), 32'(i >= 6));
      end
      chk("fill.full", 32'(if0.full), 32'd1);

      // Push while full.
      step(0, 0, 1, 0, 16'd99);
      chk("ovf.pulse", 32'(if0.overflow), 32'd1);
      chk("ovf.count", 32'(if0.count),    32'd8);
      step(0, 0, 0, 0, 16'd0);
      chk("ovf.clear", 32'(if0.overflow), 32'd0);

      // Drain in reverse order.
      for (int i = 7; i >= 0; i--) begin
         step(0, 0, 0, 1, 16'd0);
         chk("pop.out", 32'(if0.out), 32'(fill0[i]));
      end
      chk("drain.empty", 32'(if0.empty), 32'd1);
      chk("drain.count", 32'(if0.count), 32'd0);

      // Pop while empty.
      step(0, 0, 0, 1, 16'd0);
      chk("unf.pulse", 32'(if0.underflow), 32'd1);
      chk("unf.out",   32'(if0.out),       32'd100);
      step(0, 0, 0, 0, 16'd0);
      chk("unf.clear", 32'(if0.underflow), 32'd0);

      // Replace.
      step(0, 0, 1, 0, 16'd5);
      step(0, 0, 1, 0, 16'd6);
      step(0, 0, 1, 1, 16'd7);
      chk("repl.out",   32'(if0.out),   32'd6);
      chk("repl.count", 32'(if0.count), 32'd2);
      step(0, 0, 0, 1, 16'd0);
      chk("repl.pop",   32'(if0.out),   32'd7);
      step(0, 0, 0, 1, 16'd0);
      chk("repl.pop2",  32'(if0.out),   32'd5);

      // Bypass on empty.
      step(0, 0, 1, 1, 16'd33);
      chk("byp.out",   32'(if0.out),       32'd33);
      chk("byp.count", 32'(if0.count),     32'd0);
      chk("byp.unf",   32'(if0.underflow), 32'd0);
      chk("byp.ovf",   32'(if0.overflow),  32'd0);

      // Flush wins over push.
      step(0, 0, 1, 0, 16'd1);
      step(0, 0, 1, 0, 16'd2);
      step(0, 0, 1, 0, 16'd3);
      step(0, 1, 1, 0, 16'd4);
      chk("clr.count", 32'(if0.count), 32'd0);
      chk("clr.empty", 32'(if0.empty), 32'd1);
      step(0, 0, 0, 1, 16'd0);
      chk("clr.unf",   32'(if0.underflow), 32'd1);
      chk("clr.out",   32'(if0.out),       32'd33);

      // Push then pop on consecutive edges.
      step(0, 0, 1, 0, 16'd77);
      step(0, 0, 0, 1, 16'd0);
      chk("pp.out", 32'(if0.out), 32'd77);

      // Asynchronous reset mid-cycle.
      step(0, 0, 1, 0, 16'd11);
      step(0, 0, 1, 0, 16'd12);
      chk("ar.pre", 32'(if0.count), 32'd2);
      #1 rst = 1'b0;
      #1;
      chk("ar.count", 32'(if0.count), 32'd0);
      chk("ar.empty", 32'(if0.empty), 32'd1);
      chk("ar.out",   32'(if0.out),   32'd0);
      @(negedge clk);
      #2 rst = 1'b1;

      // Sweep configuration: WIDTH=16, DEPTH=5, AF_LEVEL=3.
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1, 0, fill1[i]);
         chk("sw.count", 32'(if1.count), 32'(i + 1));
         chk("sw.afull", 32'(if1.afull), 32'(i >= 2));
         chk("sw.full",  32'(if1.full),  32'(i == 4));
      end
      step(1, 0, 1, 0, 16'h5555);
      chk("sw.ovf", 32'(if1.overflow), 32'd1);
      step(1, 0, 1, 1, 16'hABCD);
      chk("sw.repl.out", 32'(if1.out),      32'hFFFF);
      chk("sw.repl.ovf", 32'(if1.overflow), 32'd0);
      chk("sw.repl.cnt", 32'(if1.count),    32'd5);
      step(1, 0, 0, 1, 16'd0);
      chk("sw.pop.top", 32'(if1.out), 32'hABCD);
      for (int i = 3; i >= 0; i--) begin
         step(1, 0, 0, 1, 16'd0);
         chk("sw.pop", 32'(if1.out), 32'(fill1[i]));
      end
      chk("sw.empty", 32'(if1.empty), 32'd1);
      step(1, 0, 0, 1, 16'd0);
      chk("sw.unf", 32'(if1.underflow), 32'd1);
      chk("sw.unf.out", 32'(if1.out), 32'hBEEF);

      step(0, 0, 0, 0, 16'd0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/lifo_stack_param.md
# lifo_stack_param

Parametrised last-in-first-out stack, the successor to the fixed 8-bit LIFO. It adds configurable data width and depth, an occupancy count, an almost-full threshold, and a synchronous flush. It also supports a defined simultaneous push/pop (replace-top) operation and one-cycle overflow/underflow error pulses. It sits between a producer that pushes operands and a consumer that pops them in reverse order, for example an expression evaluator or a backtracking controller.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of stack entries (≥2; need not be a power of two)
- AF_LEVEL, DEPTH-1, `afull` asserts when count ≥ AF_LEVEL (1..DEPTH)
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset (clears on rst=0, independent of clk)
- clr  in  1  synchronous flush; empties the stack on the next edge
- wn  in  1  push request
- rn  in  1  pop request
- in  in  WIDTH  push data
- out  out  WIDTH  registered pop data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- afull  out  1  count ≥ AF_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  one-cycle pulse: push rejected
- underflow  out  1  one-cycle pulse: pop rejected

## Operation
- Storage is DEPTH×WIDTH registers plus a stack pointer `sp` (= count). The top of stack is `mem[sp-1]`.
- Reset (rst=0): sp=0; out=0; overflow=underflow=0. Memory contents are don't-care. Flags follow combinationally from sp: empty=1, full=0, afull=(AF_LEVEL==0 ? 1 : 0), which is effectively 0.
- Per-edge priority, highest first: clr, then {wn,rn} decode.
- clr=1: sp←0, out holds, error pulses are 0, and wn/rn are ignored.
- wn=1, rn=0:
  - if not full: mem[sp]←in, sp←sp+1.
  - if full: no change, overflow=1 for one cycle.
- wn=0, rn=1:
  - if not empty: out←mem[sp-1], sp←sp-1.
  - if empty: out holds, underflow=1 for one cycle.
- wn=1, rn=1 (replace):
  - if not empty: out←mem[sp-1], mem[sp-1]←in, sp unchanged. Legal when full; no overflow.
  - if empty: bypass, out←in, sp stays 0, no error pulse.
- wn=0, rn=0: hold all state; error pulses are 0.
- overflow and underflow are registered, are asserted only in the cycle after the offending edge, and are never asserted together.
- full, empty, afull and count are combinational from sp, so they update in the same cycle as sp.
- Count arithmetic is unsigned. sp never exceeds DEPTH and never wraps below 0.

## Timing
- Push latency: data is stored at edge N. `count`/`full`/`empty` reflect it after edge N.
- Pop latency: `out` is valid after the pop edge (one-cycle registered read) and holds until the next successful pop, replace, or bypass.
- A push then a pop on consecutive edges returns the just-pushed word.
- Throughput is one operation per clock, with no stall cycles.
- An asynchronous reset asserted mid-operation aborts any in-flight edge effect. After rst rises, the first rising edge is processed normally.
- In/wn/rn are sampled only at the rising edge. There are no combinational input-to-output paths except through registers.

## Test plan
- Reset and fill: assert rst=0 and confirm out=0, empty=1, count=0. With DEPTH=8, push 100,150,200,40,70,65,15,9. Expect count=8, full=1, and afull asserted from count=7 onward.
- LIFO order: from full, pop 8 times. Expect out = 9,15,65,70,40,200,150,100, then empty=1 and count=0.
- Error pulses:
  - push while full: overflow=1 for exactly one cycle, count stays 8, top unchanged.
  - pop while empty: underflow=1 for one cycle, out keeps its last value.
- Replace and bypass:
  - push 5,6, then wn=rn=1 with in=7: out=6, count=2. The next pop gives out=7.
  - when empty, wn=rn=1 with in=33: out=33, count=0, no error.
- Flush and async reset:
  - push 3 words, assert clr with wn=1: count=0 and the push is ignored.
  - push 2 words, drop rst mid-cycle: flags clear immediately, without waiting for a clock edge.
- Parameter sweep: WIDTH=16, DEPTH=5, AF_LEVEL=3. Run fill/drain with 16-bit values (0xBEEF…). Expect count width 3, full at 5, afull at 3, and correct reverse order.
